puf_eval_ctrl: RTL and testbench
================================

# puf_eval_ctrl

Evaluation controller that sits directly around the arbiter PUF core. It drives the core's `ce` launch pulse and 32-bit challenge `sel`, and samples the core's `Q` after each race. It repeats every challenge `NUM_EVALS` times and majority-votes the result into one response bit. Over `RESP_BITS` LFSR-generated challenges it assembles a response word and hands it off on a valid/ready port.

## Interface
Parameters:
- `NUM_EVALS`, default 7: evaluations per challenge; must be odd, 1..15.
- `SETTLE`, default 4: cycles `ce` is held in each phase; must be 1..255.
- `RESP_BITS`, default 8: response bits per run; must be 1..32.

Ports:
- `clk`, in, 1: single clock. The PUF core runs on the same `clk`.
- `rst`, in, 1: asynchronous, active-high reset.
- `start`, in, 1: one-cycle request to begin a run. Sampled only in IDLE.
- `seed`, in, 32: initial challenge, captured on an accepted `start`.
- `busy`, out, 1: high whenever state is not IDLE.
- `sel`, out, 32: challenge to the PUF core.
- `ce`, out, 1: launch enable to the PUF core.
- `q`, in, 1: PUF core `Q` output.
- `resp`, out, `RESP_BITS`: voted response. `resp[i]` is the bit from challenge i.
- `unstable`, out, `RESP_BITS`: `unstable[i]` = 1 if the votes for challenge i were not unanimous.
- `resp_valid`, out, 1: `resp` and `unstable` are valid.
- `resp_ready`, in, 1: consumer accepts the result.

## Operation
- Reset: state IDLE. `sel`=0, `ce`=0, `busy`=0, `resp`=0, `unstable`=0, `resp_valid`=0. All counters are 0.
- Challenge LFSR: 32-bit Galois, right-shifting, tap mask 32'h80200003 (x^32+x^22+x^2+x+1).
  - Step: `next = (s>>1) ^ (s[0] ? 32'h80200003 : 0)`.
  - A `seed` of 0 is replaced by 32'h00000001.
  - `sel` equals the LFSR state and is constant for all evaluations of one bit.
- FSM states:
  - IDLE: on `start`=1, load the LFSR from `seed`. Clear bit index, eval count, ones count, `resp` and `unstable`. Go to LOW.
  - LOW: `ce`=0 for `SETTLE` cycles, then go to HIGH.
  - HIGH: `ce`=1 for `SETTLE` cycles, then go to SAMPLE.
  - SAMPLE: one cycle, `ce`=1.
    - Register `q` and add it to the 4-bit ones count. Increment the eval count.
    - If eval count < `NUM_EVALS`, go to LOW. Otherwise go to VOTE.
  - VOTE: one cycle, `ce`=0.
    - `resp[bit]` = (ones > `NUM_EVALS`/2).
    - `unstable[bit]` = (ones != 0 && ones != `NUM_EVALS`).
    - Step the LFSR. Clear the ones count and eval count.
    - If bit == `RESP_BITS`-1, go to DONE. Otherwise increment bit and go to LOW.
  - DONE: `resp_valid`=1. `resp` and `unstable` are held.
    - On `resp_ready`=1, go to IDLE and drop `resp_valid` the next cycle.
    - `resp` and `unstable` keep their last values in IDLE until the next accepted `start`.
- `start` outside IDLE is ignored. This includes DONE.
- A `resp_ready` not in DONE has no effect.
- Asserting `rst` at any time returns immediately to reset values. The run is aborted and no partial result is presented.

## Timing
- Registered outputs only; no combinational path from `q`, `start` or `resp_ready` to any output.
- One evaluation = 2*`SETTLE`+1 cycles. One bit = `NUM_EVALS`*(2*`SETTLE`+1)+1 cycles.
- Latency: `start` is sampled at edge 0 and `busy` rises after that edge.
  - `resp_valid` rises after edge `RESP_BITS`*(`NUM_EVALS`*(2*`SETTLE`+1)+1).
  - With defaults this is edge 512.
- `q` is sampled in SAMPLE, after `ce` has been high for `SETTLE` cycles. The core's input FF plus arbiter FF must resolve within `SETTLE` cycles, so `SETTLE` ≥ 2 is required in system use.
- Handshake: transfer occurs on the edge where `resp_valid` && `resp_ready`. `resp_valid` stays high with stable data until then.

## Test plan
- Defaults, `q` tied 1, `seed`=1, `resp_ready`=1 → `resp`=8'hFF, `unstable`=0. `resp_valid` rises 512 cycles after `start` and is high for 1 cycle. `busy` is low the next cycle.
- `q` tied 0 → `resp`=8'h00, `unstable`=0.
- `q` driven so bit 0 samples 1,1,1,0,0,0,0 and the remaining bits all 1 → `resp`=8'hFE, `unstable`=8'h01.
- `seed`=0: `sel`=32'h00000001 for bit 0, then 32'h80200003 for bit 1. `ce` toggles with 4 cycles low, 5 cycles high per evaluation.
- `resp_ready` held 0 for 20 cycles in DONE → `resp_valid` and `resp` are stable. A `start` pulse there is ignored. Releasing `resp_ready` → IDLE.
- Assert `rst` mid-run at bit 3 → next cycle `ce`=0, `sel`=0, `busy`=0, `resp_valid`=0. A fresh `start` gives a full 512-cycle run with a correct result.

Source files
------------

// File: rtl/puf_eval_ctrl.sv
// Purpose: drives the arbiter PUF core (ce launch pulse, 32-bit challenge sel), majority-votes
//          NUM_EVALS races per challenge and assembles a RESP_BITS response word.
// Latency: resp_valid rises RESP_BITS*(NUM_EVALS*(2*SETTLE+1)+1) cycles after an accepted start.
// Backpressure: the result is held with resp_valid high until resp_ready; start is ignored until then.
//
// Ports:
//   clk, rst          single clock, asynchronous active-high reset
//   start, seed       run request (sampled in IDLE only) and initial challenge
//   busy              high whenever the controller is not idle
//   sel, ce, q        challenge, launch enable and race result of the PUF core
//   resp, unstable    voted response bits and per-bit "votes were not unanimous" flags
//   resp_valid/ready  result handshake
module puf_eval_ctrl #(
    parameter int NUM_EVALS = 7,   // odd, 1..15
    parameter int SETTLE    = 4,   // 1..255
    parameter int RESP_BITS = 8    // 1..32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [31:0]          seed,
    output logic                 busy,
    output logic [31:0]          sel,
    output logic                 ce,
    input  logic                 q,
    output logic [RESP_BITS-1:0] resp,
    output logic [RESP_BITS-1:0] unstable,
    output logic                 resp_valid,
    input  logic                 resp_ready
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOW,
        S_HIGH,
        S_SAMPLE,
        S_VOTE,
        S_DONE
    } state_t;

    // x^32 + x^22 + x^2 + x + 1, Galois form, right-shifting
    localparam logic [31:0] LFSR_TAPS   = 32'h8020_0003;
    localparam logic [7:0]  SETTLE_LAST = 8'(SETTLE - 1);
    localparam logic [3:0]  N_EVALS     = 4'(NUM_EVALS);
    localparam logic [3:0]  MAJ_THRESH  = 4'(NUM_EVALS / 2);
    localparam logic [4:0]  LAST_BIT    = 5'(RESP_BITS - 1);

    state_t                 state_q, state_d;
    logic [7:0]             cnt_q, cnt_d;       // cycles spent in current LOW/HIGH phase
    logic [3:0]             eval_q, eval_d;     // evaluations done for current challenge
    logic [3:0]             ones_q, ones_d;     // votes for 1 on current challenge
    logic [4:0]             bit_q, bit_d;       // response bit being produced
    logic [31:0]            lfsr_q, lfsr_d;
    logic [RESP_BITS-1:0]   resp_q, resp_d;
    logic [RESP_BITS-1:0]   unst_q, unst_d;
    logic                   ce_q, ce_d;
    logic                   busy_q, busy_d;
    logic                   valid_q, valid_d;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_TAPS : 32'h0);
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        eval_d  = eval_q;
        ones_d  = ones_q;
        bit_d   = bit_q;
        lfsr_d  = lfsr_q;
        resp_d  = resp_q;
        unst_d  = unst_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    // an all-zero state would lock the LFSR
                    lfsr_d  = (seed == 32'h0) ? 32'h1 : seed;
                    cnt_d   = '0;
                    eval_d  = '0;
                    ones_d  = '0;
                    bit_d   = '0;
                    resp_d  = '0;
                    unst_d  = '0;
                    state_d = S_LOW;
                end
            end
            S_LOW: begin
                if (cnt_q == SETTLE_LAST) begin
                    cnt_d   = '0;
                    state_d = S_HIGH;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_HIGH: begin
                if (cnt_q == SETTLE_LAST) begin
                    cnt_d   = '0;
                    state_d = S_SAMPLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_SAMPLE: begin
                ones_d = ones_q + {3'b000, q};
                eval_d = eval_q + 4'd1;
                state_d = ((eval_q + 4'd1) < N_EVALS) ? S_LOW : S_VOTE;
            end
            S_VOTE: begin
                for (int i = 0; i < RESP_BITS; i++) begin
                    if (bit_q == 5'(i)) begin
                        resp_d[i] = (ones_q > MAJ_THRESH);
                        unst_d[i] = (ones_q != 4'd0) && (ones_q != N_EVALS);
                    end
                end
                lfsr_d = lfsr_step(lfsr_q);
                ones_d = '0;
                eval_d = '0;
                if (bit_q == LAST_BIT) begin
                    state_d = S_DONE;
                end else begin
                    bit_d   = bit_q + 5'd1;
                    state_d = S_LOW;
                end
            end
            S_DONE: begin
                if (resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are flopped from the next state so they line up with the state register.
        ce_d    = (state_d == S_HIGH) || (state_d == S_SAMPLE);
        busy_d  = (state_d != S_IDLE);
        valid_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            eval_q  <= '0;
            ones_q  <= '0;
            bit_q   <= '0;
            lfsr_q  <= '0;
            resp_q  <= '0;
            unst_q  <= '0;
            ce_q    <= 1'b0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            eval_q  <= eval_d;
            ones_q  <= ones_d;
            bit_q   <= bit_d;
            lfsr_q  <= lfsr_d;
            resp_q  <= resp_d;
            unst_q  <= unst_d;
            ce_q    <= ce_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
        end
    end

    assign sel        = lfsr_q;
    assign ce         = ce_q;
    assign busy       = busy_q;
    assign resp       = resp_q;
    assign unstable   = unst_q;
    assign resp_valid = valid_q;

endmodule

// File: tb/tb_puf_eval_ctrl.sv
// Purpose: self-checking bench for puf_eval_ctrl; directed and randomized runs against a reference model.
// Latency: each run spans RESP_BITS*(NUM_EVALS*(2*SETTLE+1)+1) cycles from start to resp_valid.
// Backpressure: exercises held results with resp_ready low in DONE and ignored start pulses.
module tb_puf_eval_ctrl;

    localparam int NE   = 7;
    localparam int S    = 4;
    localparam int RB   = 8;
    localparam int EV   = 2 * S + 1;          // cycles per evaluation
    localparam int BITC = NE * EV + 1;        // cycles per response bit
    localparam int TOT  = RB * BITC;          // cycles from start to resp_valid

    logic          clk;
    logic          rst;
    logic          start;
    logic [31:0]   seed;
    logic          busy;
    logic [31:0]   sel;
    logic          ce;
    logic          q;
    logic [RB-1:0] resp;
    logic [RB-1:0] unstable;
    logic          resp_valid;
    logic          resp_ready;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    bit pat [RB][NE];   // q value the core returns for each (bit, evaluation)

    puf_eval_ctrl #(.NUM_EVALS(NE), .SETTLE(S), .RESP_BITS(RB)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .seed       (seed),
        .busy       (busy),
        .sel        (sel),
        .ce         (ce),
        .q          (q),
        .resp       (resp),
        .unstable   (unstable),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0);
    endfunction

    // mode 0: all ones, 1: all zeros, 2: random per bit, 3: bit0 = 1,1,1,0,0,0,0 rest ones
    task automatic fill(input int mode);
        for (int b = 0; b < RB; b++) begin
            int m;
            m = (mode == 2) ? int'($urandom % 3) : mode;
            for (int e = 0; e < NE; e++) begin
                case (m)
                    0:       pat[b][e] = 1'b1;
                    1:       pat[b][e] = 1'b0;
                    2:       pat[b][e] = 1'($urandom);
                    default: pat[b][e] = (b == 0) ? (e < 3) : 1'b1;
                endcase
            end
        end
    endtask

    // hold: cycles resp_ready stays low in DONE (0 = accept immediately)
    // abort_t: cycle after start at which rst is pulsed (-1 = none)
    task automatic run(input logic [31:0] sd, input int hold, input int abort_t);
        logic [31:0]   s;
        logic [31:0]   selm [RB];
        logic [RB-1:0] er;
        logic [RB-1:0] eu;
        bit            aborted;

        s = (sd == 32'h0) ? 32'h1 : sd;
        for (int b = 0; b < RB; b++) begin
            int ones;
            selm[b] = s;
            s = lfsr_next(s);
            ones = 0;
            for (int e = 0; e < NE; e++) ones += int'(pat[b][e]);
            er[b] = (ones > NE / 2);
            eu[b] = (ones != 0) && (ones != NE);
        end

        resp_ready = 1'b0;
        @(negedge clk);
        start = 1'b1;
        seed  = sd;
        @(negedge clk);
        start = 1'b0;
        seed  = $urandom;
        aborted = 1'b0;

        for (int t = 0; t < TOT && !aborted; t++) begin
            int b;
            int u;
            b = t / BITC;
            u = t % BITC;
            q = (u < NE * EV) ? pat[b][u / EV] : 1'($urandom);
            resp_ready = (hold == 0) ? 1'($urandom) : 1'b0;
            chk("busy_run", busy, 1);
            chk("valid_run", resp_valid, 0);
            chk("ce_run", ce, (u < NE * EV) && ((u % EV) >= S));
            chk("sel_run", sel, selm[b]);
            if (t == abort_t) begin
                rst = 1'b1;
                #1;
                chk("rst_ce", ce, 0);
                chk("rst_sel", sel, 0);
                chk("rst_busy", busy, 0);
                chk("rst_valid", resp_valid, 0);
                chk("rst_resp", resp, 0);
                @(negedge clk);
                rst = 1'b0;
                chk("rst_ce_next", ce, 0);
                chk("rst_busy_next", busy, 0);
                aborted = 1'b1;
            end else begin
                @(negedge clk);
            end
        end

        if (!aborted) begin
            resp_ready = (hold == 0);
            chk("valid_done", resp_valid, 1);
            chk("busy_done", busy, 1);
            chk("ce_done", ce, 0);
            chk("resp_done", resp, er);
            chk("unst_done", unstable, eu);
            for (int k = 0; k < hold; k++) begin
                start = (k == 5);
                @(negedge clk);
                chk("valid_hold", resp_valid, 1);
                chk("busy_hold", busy, 1);
                chk("resp_hold", resp, er);
                chk("unst_hold", unstable, eu);
            end
            start = 1'b0;
            resp_ready = 1'b1;
            @(negedge clk);
            resp_ready = 1'b0;
            chk("valid_after", resp_valid, 0);
            chk("busy_after", busy, 0);
            chk("resp_idle", resp, er);
            chk("unst_idle", unstable, eu);
            @(negedge clk);
            chk("busy_idle", busy, 0);
            chk("valid_idle", resp_valid, 0);
        end
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        seed       = '0;
        q          = 1'b0;
        resp_ready = 1'b0;
        #1;
        chk("reset_busy", busy, 0);
        chk("reset_ce", ce, 0);
        chk("reset_sel", sel, 0);
        chk("reset_resp", resp, 0);
        chk("reset_unst", unstable, 0);
        chk("reset_valid", resp_valid, 0);
        @(negedge clk);
        rst = 1'b0;

        // q tied 1, seed 1
        fill(0);
        run(32'h1, 0, -1);
        // q tied 0
        fill(1);
        run(32'h1234_5678, 0, -1);
        // bit 0 split 3/4, others unanimous ones
        fill(3);
        run(32'hDEAD_BEEF, 0, -1);
        // zero seed substitution
        fill(2);
        run(32'h0, 0, -1);
        // result held while consumer stalls, start ignored in DONE
        fill(2);
        run($urandom, 20, -1);
        // reset mid-run at bit 3, then a fresh complete run
        fill(2);
        run($urandom, 0, 3 * BITC + 20);
        fill(2);
        run($urandom, 0, -1);
        // randomized runs
        for (int r = 0; r < 4; r++) begin
            fill(2);
            run(($urandom % 4 == 0) ? 32'h0 : $urandom, int'($urandom % 3), -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
